// File: rtl/ber_counter.sv
// Bit-error accumulator: counts compared bits and errors per window,
// keeps saturating totals and hands each window result to the host.
module ber_counter #(
    parameter int WINDOW  = 1024,
    parameter int WIN_W   = $clog2(WINDOW + 1),
    parameter int TOT_W   = 32,
    parameter int ERR_THR = 0
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_valid,
    input  logic             i_match,
    input  logic             i_start,
    input  logic             i_continuous,
    input  logic             i_clear,
    input  logic             i_rpt_ack,
    output logic             o_busy,
    output logic             o_rpt_valid,
    output logic [WIN_W-1:0] o_win_bits,
    output logic [WIN_W-1:0] o_win_errors,
    output logic [TOT_W-1:0] o_tot_bits,
    output logic [TOT_W-1:0] o_tot_errors,
    output logic             o_lock,
    output logic             o_overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [WIN_W-1:0] LAST_IDX = WIN_W'(WINDOW - 1);
    localparam logic [WIN_W-1:0] WIN_LEN  = WIN_W'(WINDOW);
    localparam logic [WIN_W-1:0] THR =
        (ERR_THR >= WINDOW) ? WIN_W'(WINDOW) : WIN_W'(ERR_THR);

    state_t             state_q, state_d;
    logic [WIN_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIN_W-1:0]   err_cnt_q, err_cnt_d;
    logic [WIN_W-1:0]   win_bits_q, win_bits_d;
    logic [WIN_W-1:0]   win_err_q, win_err_d;
    logic [TOT_W-1:0]   tot_bits_q, tot_bits_d;
    logic [TOT_W-1:0]   tot_err_q, tot_err_d;
    logic               busy_q, busy_d;
    logic               rpt_valid_q, rpt_valid_d;
    logic               lock_q, lock_d;
    logic               overrun_q, overrun_d;

    logic               accept;
    logic               miss;
    logic               last;
    logic               win_done;
    logic [WIN_W-1:0]   err_final;

    assign accept    = i_valid && i_enable && (state_q == S_RUN);
    assign miss      = ~i_match;
    assign last      = (bit_cnt_q == LAST_IDX);
    assign err_final = err_cnt_q + {{(WIN_W-1){1'b0}}, miss};

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        err_cnt_d   = err_cnt_q;
        win_bits_d  = win_bits_q;
        win_err_d   = win_err_q;
        tot_bits_d  = tot_bits_q;
        tot_err_d   = tot_err_q;
        rpt_valid_d = rpt_valid_q;
        lock_d      = lock_q;
        overrun_d   = overrun_q;
        win_done    = 1'b0;

        if (i_clear) begin
            state_d     = S_IDLE;
            bit_cnt_d   = '0;
            err_cnt_d   = '0;
            win_bits_d  = '0;
            win_err_d   = '0;
            tot_bits_d  = '0;
            tot_err_d   = '0;
            rpt_valid_d = 1'b0;
            lock_d      = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            // Totals count every accepted sample, even one hit by a restart.
            if (accept) begin
                if (tot_bits_q != '1) begin
                    tot_bits_d = tot_bits_q + TOT_W'(1);
                end
                if (miss && (tot_err_q != '1)) begin
                    tot_err_d = tot_err_q + TOT_W'(1);
                end
            end

            if (i_start) begin
                state_d   = S_RUN;
                bit_cnt_d = '0;
                err_cnt_d = '0;
            end else if (accept) begin
                if (last) begin
                    win_done    = 1'b1;
                    win_bits_d  = WIN_LEN;
                    win_err_d   = err_final;
                    lock_d      = (err_final <= THR);
                    rpt_valid_d = 1'b1;
                    if (rpt_valid_q && !i_rpt_ack) begin
                        overrun_d = 1'b1;
                    end
                    bit_cnt_d = '0;
                    err_cnt_d = '0;
                    state_d   = i_continuous ? S_RUN : S_DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q + WIN_W'(1);
                    err_cnt_d = err_final;
                end
            end

            if (i_rpt_ack && rpt_valid_q && !win_done) begin
                rpt_valid_d = 1'b0;
            end
        end

        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
            win_bits_q  <= '0;
            win_err_q   <= '0;
            tot_bits_q  <= '0;
            tot_err_q   <= '0;
            busy_q      <= 1'b0;
            rpt_valid_q <= 1'b0;
            lock_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
            win_bits_q  <= win_bits_d;
            win_err_q   <= win_err_d;
            tot_bits_q  <= tot_bits_d;
            tot_err_q   <= tot_err_d;
            busy_q      <= busy_d;
            rpt_valid_q <= rpt_valid_d;
            lock_q      <= lock_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_busy       = busy_q;
    assign o_rpt_valid  = rpt_valid_q;
    assign o_win_bits   = win_bits_q;
    assign o_win_errors = win_err_q;
    assign o_tot_bits   = tot_bits_q;
    assign o_tot_errors = tot_err_q;
    assign o_lock       = lock_q;
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_ber_counter.sv
// Directed bench for ber_counter: vector table plus hand-written
// sequences for continuous mode, restarts, saturation and reset.
module tb_ber_counter;

    localparam int WIN = 8;
    localparam int WW  = $clog2(WIN + 1);

    logic clock = 1'b0;
    logic i_reset = 1'b0;
    logic i_enable = 1'b1;
    logic i_valid = 1'b0;
    logic i_match = 1'b1;
    logic i_start = 1'b0;
    logic i_continuous = 1'b0;
    logic i_clear = 1'b0;
    logic i_rpt_ack = 1'b0;

    logic          busy, rv, lock, ovr;
    logic [WW-1:0] wbits, werr;
    logic [31:0]   tbits, terr;

    logic          busy4, rv4, lock4, ovr4;
    logic [WW-1:0] wbits4, werr4;
    logic [3:0]    tbits4, terr4;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ber_counter #(.WINDOW(WIN), .TOT_W(32), .ERR_THR(0)) dut (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable),
        .i_valid(i_valid), .i_match(i_match), .i_start(i_start),
        .i_continuous(i_continuous), .i_clear(i_clear),
        .i_rpt_ack(i_rpt_ack), .o_busy(busy), .o_rpt_valid(rv),
        .o_win_bits(wbits), .o_win_errors(werr),
        .o_tot_bits(tbits), .o_tot_errors(terr),
        .o_lock(lock), .o_overrun(ovr)
    );

    ber_counter #(.WINDOW(WIN), .TOT_W(4), .ERR_THR(0)) dut4 (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable),
        .i_valid(i_valid), .i_match(i_match), .i_start(i_start),
        .i_continuous(i_continuous), .i_clear(i_clear),
        .i_rpt_ack(i_rpt_ack), .o_busy(busy4), .o_rpt_valid(rv4),
        .o_win_bits(wbits4), .o_win_errors(werr4),
        .o_tot_bits(tbits4), .o_tot_errors(terr4),
        .o_lock(lock4), .o_overrun(ovr4)
    );

    typedef struct {
        logic        st, v, en, m, ak;
        logic        rv, busy;
        logic [3:0]  werr;
        logic [31:0] tb, te;
        logic        lock;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic m,
                       input logic st, input logic ak);
        i_valid   = v;
        i_match   = m;
        i_start   = st;
        i_rpt_ack = ak;
        @(posedge clock);
        #1;
        i_valid   = 1'b0;
        i_match   = 1'b1;
        i_start   = 1'b0;
        i_rpt_ack = 1'b0;
    endtask

    task automatic samples(input int n, input logic m);
        for (int k = 0; k < n; k++) cyc(1'b1, m, 1'b0, 1'b0);
    endtask

    task automatic do_clear();
        i_clear = 1'b1;
        @(posedge clock);
        #1;
        i_clear = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, {31'd0, busy}, 0);
        chk({nm, "_rv"}, {31'd0, rv}, 0);
        chk({nm, "_wbits"}, {28'd0, wbits}, 0);
        chk({nm, "_werr"}, {28'd0, werr}, 0);
        chk({nm, "_tbits"}, tbits, 0);
        chk({nm, "_terr"}, terr, 0);
        chk({nm, "_lock"}, {31'd0, lock}, 0);
        chk({nm, "_ovr"}, {31'd0, ovr}, 0);
    endtask

    initial begin
        // st v en m ak | rv busy werr tb te lock
        tbl[0]  = '{1'b0,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b0,4'd0,32'd8, 32'd0,1'b1};
        tbl[1]  = '{1'b1,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,4'd0,32'd8, 32'd0,1'b1};
        tbl[2]  = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b1,4'd0,32'd9, 32'd0,1'b1};
        tbl[3]  = '{1'b0,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b1,4'd0,32'd9, 32'd0,1'b1};
        tbl[4]  = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b1,4'd0,32'd10,32'd0,1'b1};
        tbl[5]  = '{1'b0,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b1,4'd0,32'd10,32'd0,1'b1};
        tbl[6]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,4'd0,32'd11,32'd1,1'b1};
        tbl[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,4'd0,32'd11,32'd1,1'b1};
        tbl[8]  = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b1,4'd0,32'd12,32'd1,1'b1};
        tbl[9]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,4'd0,32'd12,32'd1,1'b1};
        tbl[10] = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b1,4'd0,32'd13,32'd1,1'b1};
        tbl[11] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,4'd0,32'd13,32'd1,1'b1};
        tbl[12] = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b1,4'd0,32'd14,32'd1,1'b1};
        tbl[13] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,4'd0,32'd14,32'd1,1'b1};
        tbl[14] = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b1,4'd0,32'd15,32'd1,1'b1};
        tbl[15] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,4'd0,32'd15,32'd1,1'b1};
        tbl[16] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,4'd2,32'd16,32'd2,1'b0};

        #12;
        chk_zero("reset");
        i_reset = 1'b1;
        #1;

        // Single window, all matches, stops in DONE.
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t1_busy_start", {31'd0, busy}, 1);
        samples(7, 1'b1);
        chk("t1_rv_early", {31'd0, rv}, 0);
        samples(1, 1'b1);
        chk("t1_rv", {31'd0, rv}, 1);
        chk("t1_wbits", {28'd0, wbits}, 8);
        chk("t1_werr", {28'd0, werr}, 0);
        chk("t1_lock", {31'd0, lock}, 1);
        chk("t1_tbits", tbits, 8);
        chk("t1_busy", {31'd0, busy}, 0);
        samples(1, 1'b0);
        chk("t1_done_ignore", tbits, 8);
        chk("t1_done_rv", {31'd0, rv}, 1);

        // Errors on samples 3 and 8, valid toggling, one enable-low gap.
        for (int i = 0; i < 17; i++) begin
            i_enable = tbl[i].en;
            cyc(tbl[i].v, tbl[i].m, tbl[i].st, tbl[i].ak);
            i_enable = 1'b1;
            chk($sformatf("t2_rv[%0d]", i), {31'd0, rv}, {31'd0, tbl[i].rv});
            chk($sformatf("t2_busy[%0d]", i), {31'd0, busy},
                {31'd0, tbl[i].busy});
            chk($sformatf("t2_werr[%0d]", i), {28'd0, werr},
                {28'd0, tbl[i].werr});
            chk($sformatf("t2_tb[%0d]", i), tbits, tbl[i].tb);
            chk($sformatf("t2_te[%0d]", i), terr, tbl[i].te);
            chk($sformatf("t2_lock[%0d]", i), {31'd0, lock},
                {31'd0, tbl[i].lock});
        end

        // Clear, then three continuous windows without acks.
        do_clear();
        chk_zero("clear");
        i_continuous = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        samples(8, 1'b1);
        chk("t3_w1_rv", {31'd0, rv}, 1);
        chk("t3_w1_ovr", {31'd0, ovr}, 0);
        samples(3, 1'b1);
        samples(1, 1'b0);
        samples(4, 1'b1);
        chk("t3_w2_ovr", {31'd0, ovr}, 1);
        chk("t3_w2_werr", {28'd0, werr}, 1);
        chk("t3_w2_lock", {31'd0, lock}, 0);
        chk("t3_w2_busy", {31'd0, busy}, 1);
        samples(8, 1'b1);
        chk("t3_w3_werr", {28'd0, werr}, 0);
        chk("t3_w3_lock", {31'd0, lock}, 1);
        chk("t3_tbits", tbits, 24);
        chk("t3_terr", terr, 1);
        chk("t3_ovr", {31'd0, ovr}, 1);
        i_continuous = 1'b0;

        // Ack coincident with a completing window.
        do_clear();
        i_continuous = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        samples(8, 1'b1);
        samples(7, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t4_rv", {31'd0, rv}, 1);
        chk("t4_werr", {28'd0, werr}, 1);
        chk("t4_ovr", {31'd0, ovr}, 0);
        chk("t4_lock", {31'd0, lock}, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("t4_ack_rv", {31'd0, rv}, 0);
        i_continuous = 1'b0;

        // Restart on sample 5, then a full window.
        do_clear();
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        samples(4, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t5_restart_tb", tbits, 5);
        chk("t5_restart_busy", {31'd0, busy}, 1);
        samples(7, 1'b1);
        chk("t5_rv_early", {31'd0, rv}, 0);
        samples(1, 1'b1);
        chk("t5_rv", {31'd0, rv}, 1);
        chk("t5_wbits", {28'd0, wbits}, 8);
        chk("t5_tbits", tbits, 13);

        // Start coincident with the completing sample discards the window.
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("t5b_ack_rv", {31'd0, rv}, 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        samples(7, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t5b_rv", {31'd0, rv}, 0);
        chk("t5b_tbits", tbits, 21);
        chk("t5b_terr", terr, 1);
        chk("t5b_busy", {31'd0, busy}, 1);

        // Saturation of a 4-bit total.
        do_clear();
        i_continuous = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        samples(20, 1'b0);
        chk("t6_sat_terr", {28'd0, terr4}, 15);
        chk("t6_sat_tbits", {28'd0, tbits4}, 15);
        chk("t6_terr", terr, 20);
        chk("t6_tbits", tbits, 20);
        i_continuous = 1'b0;

        // Asynchronous reset in the middle of a window.
        do_clear();
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        samples(3, 1'b0);
        chk("t7_pre_tbits", tbits, 3);
        #2;
        i_reset = 1'b0;
        #1;
        chk_zero("areset");
        chk("areset_tb4", {28'd0, tbits4}, 0);
        @(posedge clock);
        #3;
        i_reset = 1'b1;
        #1;
        samples(1, 1'b1);
        chk("t7_idle_tbits", tbits, 0);
        chk("t7_idle_busy", {31'd0, busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
